// File: rtl/mem_arbiter.sv
// Memory arbiter: icache fetches and dcache loads/stores onto one single-ported RAM.
// dcache is preferred; a starvation counter forces an icache grant after STARVE_MAX dcache wins.
module mem_arbiter #(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int ERRCNT_W   = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                iREN,
    input  logic [WORD_W-1:0]   iaddr,
    output logic                iwait,
    output logic [WORD_W-1:0]   iload,
    input  logic                dREN,
    input  logic                dWEN,
    input  logic [WORD_W-1:0]   daddr,
    input  logic [WORD_W-1:0]   dstore,
    output logic                dwait,
    output logic [WORD_W-1:0]   dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [WORD_W-1:0]   ramaddr,
    output logic [WORD_W-1:0]   ramstore,
    input  logic [WORD_W-1:0]   ramload,
    input  logic [1:0]          ramstate,
    output logic [ERRCNT_W-1:0] err_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT
    } state_t;

    state_t            state;
    state_t            next;
    logic [SW-1:0]     starve;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_store;
    logic              lat_wr;
    logic              dreq;
    logic              dpick;
    logic              granted;
    logic              done;
    logic              fault;

    assign dreq    = dREN | dWEN;
    // dcache wins unless icache is waiting and has already been passed over STARVE_MAX times
    assign dpick   = dreq && (!iREN || (starve < SMAX));
    assign granted = (state != IDLE);
    assign done    = granted && (ramstate == RS_ACCESS);
    assign fault   = granted && (ramstate == RS_ERROR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        case (state)
            IDLE: begin
                if (dpick) begin
                    next = DGNT;
                end else if (iREN) begin
                    next = IGNT;
                end
            end
            IGNT, DGNT: begin
                if (ramstate == RS_ACCESS) begin
                    next = IDLE;
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            lat_addr  <= '0;
            lat_store <= '0;
            lat_wr    <= 1'b0;
        end else if (state == IDLE) begin
            if (dpick) begin
                lat_addr  <= daddr;
                lat_store <= dstore;
                lat_wr    <= dWEN;
            end else if (iREN) begin
                lat_addr  <= iaddr;
                lat_store <= '0;
                lat_wr    <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            starve <= '0;
        end else if (done) begin
            if ((state == DGNT) && iREN) begin
                if (starve != SMAX) begin
                    starve <= starve + SW'(1);
                end
            end else begin
                starve <= '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt <= '0;
        end else if (fault && (err_cnt != {ERRCNT_W{1'b1}})) begin
            err_cnt <= err_cnt + ERRCNT_W'(1);
        end
    end

    // RST also masks the outputs so they are quiet before the first reset edge
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (!RST && granted) begin
            ramaddr  = lat_addr;
            ramREN   = !lat_wr;
            ramWEN   = lat_wr;
            ramstore = lat_wr ? lat_store : '0;
            if (done) begin
                if (state == IGNT) begin
                    iwait = 1'b0;
                    iload = ramload;
                end else begin
                    dwait = 1'b0;
                    dload = lat_wr ? '0 : ramload;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// transactions checked against a transaction-level arbitration model.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic [7:0]  err_cnt;

    int    total;
    int    passes;
    int    m_starve;
    int    m_err;
    string step;

    mem_arbiter #(
        .WORD_W    (32),
        .STARVE_MAX(4),
        .ERRCNT_W  (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .iREN    (iREN),
        .iaddr   (iaddr),
        .iwait   (iwait),
        .iload   (iload),
        .dREN    (dREN),
        .dWEN    (dWEN),
        .daddr   (daddr),
        .dstore  (dstore),
        .dwait   (dwait),
        .dload   (dload),
        .ramREN  (ramREN),
        .ramWEN  (ramWEN),
        .ramaddr (ramaddr),
        .ramstore(ramstore),
        .ramload (ramload),
        .ramstate(ramstate),
        .err_cnt (err_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s/%s: observed %0h expected %0h", step, tag, obs, exp);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s/%s: observed %0b expected %0b", step, tag, obs, exp);
    endtask

    // 0 = nobody, 1 = icache, 2 = dcache
    function automatic int predict(input bit ireq, input bit dreq);
        if (dreq && (!ireq || m_starve < 4)) return 2;
        if (ireq) return 1;
        return 0;
    endfunction

    task automatic idle();
        ramstate = 2'd0;
        @(negedge CLK);
        chk1("idle_ren", ramREN, 1'b0);
        chk1("idle_wen", ramWEN, 1'b0);
        chk1("idle_iwait", iwait, 1'b1);
        chk1("idle_dwait", dwait, 1'b1);
        @(posedge CLK);
        #1;
    endtask

    // Acts as the RAM for one granted access: nerr ERROR cycles, nbusy hold
    // cycles, then ACCESS. Cache address/data inputs are scrambled meanwhile.
    task automatic run_grant(input bit own_d, input bit wr,
                             input logic [31:0] addr, input logic [31:0] store,
                             input int nerr, input int nbusy,
                             input logic [31:0] load);
        for (int c = 0; c < nerr + nbusy; c++) begin
            if (c < nerr) ramstate = 2'd3;
            else ramstate = ($urandom_range(1, 0) != 0) ? 2'd1 : 2'd0;
            ramload = $urandom;
            iaddr   = $urandom;
            daddr   = $urandom;
            dstore  = $urandom;
            @(negedge CLK);
            chk1("ren", ramREN, !wr);
            chk1("wen", ramWEN, wr);
            chk("addr", ramaddr, addr);
            if (wr) chk("store", ramstore, store);
            chk1("iwait_hold", iwait, 1'b1);
            chk1("dwait_hold", dwait, 1'b1);
            chk("iload_hold", iload, 32'h0);
            chk("dload_hold", dload, 32'h0);
            chk("errcnt", 32'(err_cnt), 32'(m_err));
            @(posedge CLK);
            #1;
            if (c < nerr && m_err < 255) m_err++;
        end
        ramstate = 2'd2;
        ramload  = load;
        @(negedge CLK);
        chk1("ren_acc", ramREN, !wr);
        chk1("wen_acc", ramWEN, wr);
        chk("addr_acc", ramaddr, addr);
        chk1("iwait_acc", iwait, own_d);
        chk1("dwait_acc", dwait, !own_d);
        chk("iload_acc", iload, own_d ? 32'h0 : load);
        chk("dload_acc", dload, (own_d && !wr) ? load : 32'h0);
        chk("errcnt_acc", 32'(err_cnt), 32'(m_err));
        if (own_d && iREN) m_starve = (m_starve < 4) ? m_starve + 1 : 4;
        else m_starve = 0;
        @(posedge CLK);
        #1;
        ramstate = 2'd0;
    endtask

    initial begin
        int          seq [6];
        int          who;
        bit          ir;
        bit          dr;
        bit          dw;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] ds;

        total    = 0;
        passes   = 0;
        m_starve = 0;
        m_err    = 0;
        seq      = '{2, 2, 2, 2, 1, 2};
        iaddr    = 32'h0;
        daddr    = 32'h10;
        dstore   = 32'h0;
        ramload  = 32'h0;
        ramstate = 2'd0;
        dWEN     = 1'b0;
        iREN     = 1'b1;
        dREN     = 1'b1;
        RST      = 1'b1;

        step = "reset";
        @(negedge CLK);
        chk1("iwait", iwait, 1'b1);
        chk1("dwait", dwait, 1'b1);
        chk1("ren", ramREN, 1'b0);
        chk("ramaddr", ramaddr, 32'h0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk1("ren2", ramREN, 1'b0);
        chk1("wen2", ramWEN, 1'b0);
        chk("errcnt", 32'(err_cnt), 32'h0);
        chk("iload", iload, 32'h0);
        chk("dload", dload, 32'h0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        idle();
        run_grant(1'b1, 1'b0, 32'h10, 32'h0, 0, 1, 32'h0BADF00D);

        step = "simple_read";
        dREN  = 1'b0;
        iaddr = 32'h40;
        idle();
        run_grant(1'b0, 1'b0, 32'h40, 32'h0, 0, 3, 32'hDEADBEEF);
        iREN = 1'b0;
        idle();

        step = "priority";
        iREN   = 1'b1;
        iaddr  = 32'h44;
        dWEN   = 1'b1;
        daddr  = 32'h80;
        dstore = 32'h1234;
        idle();
        run_grant(1'b1, 1'b1, 32'h80, 32'h1234, 0, 1, $urandom);
        dWEN  = 1'b0;
        iaddr = 32'h44;
        idle();
        run_grant(1'b0, 1'b0, 32'h44, 32'h0, 0, 0, 32'hCAFE0001);

        step = "starve";
        iREN = 1'b1;
        dREN = 1'b1;
        for (int k = 0; k < 6; k++) begin
            iaddr = 32'h100;
            daddr = 32'h200;
            idle();
            run_grant(seq[k] == 2, 1'b0, (seq[k] == 2) ? 32'h200 : 32'h100,
                      32'h0, 0, 1, $urandom);
        end

        step = "err_retry";
        iREN  = 1'b0;
        dREN  = 1'b1;
        daddr = 32'h300;
        idle();
        run_grant(1'b1, 1'b0, 32'h300, 32'h0, 2, 0, 32'h5A5A5A5A);
        dREN = 1'b0;
        @(negedge CLK);
        chk("errcnt2", 32'(err_cnt), 32'd2);
        @(posedge CLK);
        #1;

        step = "random";
        for (int n = 0; n < 40; n++) begin
            ir = 1'($urandom_range(1, 0));
            dr = 1'($urandom_range(1, 0));
            dw = 1'($urandom_range(1, 0));
            ia = $urandom;
            da = $urandom;
            ds = $urandom;
            iREN   = ir;
            dREN   = dr && !dw;
            dWEN   = dr && dw;
            iaddr  = ia;
            daddr  = da;
            dstore = ds;
            who    = predict(ir, dr);
            idle();
            if (who != 0) begin
                if ($urandom_range(3, 0) == 0) begin
                    iREN = 1'($urandom_range(1, 0));
                    dREN = 1'b0;
                    dWEN = 1'b0;
                end
                run_grant(who == 2, (who == 2) && dw, (who == 2) ? da : ia, ds,
                          int'($urandom_range(2, 0)), int'($urandom_range(3, 0)),
                          $urandom);
            end
        end

        step = "saturate";
        iREN  = 1'b0;
        dWEN  = 1'b0;
        dREN  = 1'b1;
        daddr = 32'h400;
        idle();
        run_grant(1'b1, 1'b0, 32'h400, 32'h0, 300, 0, $urandom);
        dREN = 1'b0;
        @(negedge CLK);
        chk("errcnt_sat", 32'(err_cnt), 32'd255);
        @(posedge CLK);
        #1;

        step = "reset_mid";
        iREN  = 1'b1;
        iaddr = 32'h500;
        idle();
        ramstate = 2'd1;
        @(negedge CLK);
        chk1("ren_pre", ramREN, 1'b1);
        chk("addr_pre", ramaddr, 32'h500);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST      = 1'b0;
        iREN     = 1'b0;
        ramstate = 2'd2;
        ramload  = 32'h77777777;
        @(negedge CLK);
        chk1("ren_post", ramREN, 1'b0);
        chk1("iwait_post", iwait, 1'b1);
        chk("iload_post", iload, 32'h0);
        chk("errcnt_post", 32'(err_cnt), 32'h0);
        @(posedge CLK);
        #1;
        ramstate = 2'd0;
        @(negedge CLK);
        chk1("iwait_post2", iwait, 1'b1);
        chk1("ren_post2", ramREN, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
